demux_frame_sequencer: RTL



---
 rtl/demux_frame_sequencer_if.sv | 24 ++
 rtl/demux_frame_sequencer.sv | 96 +++++++++
 2 files changed

// File: rtl/demux_frame_sequencer_if.sv
// demux_frame_sequencer_if: frame handshake plus demux drive signals of the frame sequencer
interface demux_frame_sequencer_if #(
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [NUM_CH-1:0] in_frame;
  logic [NUM_CH-1:0] in_mask;
  logic              abort;
  logic              data;
  logic [SEL_W-1:0]  sel;
  logic              strobe;
  logic              busy;
  logic              frame_done;
  modport master (
    output in_valid, in_frame, in_mask, abort,
    input  in_ready, data, sel, strobe, busy, frame_done
  );
  modport slave (
    input  in_valid, in_frame, in_mask, abort,
    output in_ready, data, sel, strobe, busy, frame_done
  );
endinterface

// File: rtl/demux_frame_sequencer.sv
// demux_frame_sequencer: scans enabled channels of a latched frame onto a 1:NUM_CH demux
module demux_frame_sequencer #(
  parameter int NUM_CH      = 16,
  parameter int SEL_W       = 4,
  parameter int HOLD_CYCLES = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  demux_frame_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t            state;
  logic [NUM_CH-1:0] frame_q;
  logic [NUM_CH-1:0] mask_q;
  logic [7:0]        hold_cnt;
  logic [SEL_W-1:0]  first_sel;
  logic [SEL_W-1:0]  next_sel;
  function automatic logic [SEL_W-1:0] lowest(input logic [NUM_CH-1:0] v);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (v[i]) lowest = SEL_W'(i);
  endfunction
  always_comb begin
    first_sel = lowest(bus.in_mask);
    next_sel  = lowest(mask_q);
  end
  // mask_q holds only the channels still to be delivered after the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      frame_q        <= '0;
      mask_q         <= '0;
      hold_cnt       <= '0;
      bus.in_ready   <= 1'b0;
      bus.data       <= 1'b0;
      bus.sel        <= '0;
      bus.strobe     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            frame_q      <= bus.in_frame;
            mask_q       <= bus.in_mask & (bus.in_mask - NUM_CH'(1));
            hold_cnt     <= '0;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            if (|bus.in_mask) begin
              state      <= SCAN;
              bus.sel    <= first_sel;
              bus.data   <= bus.in_frame[first_sel];
              bus.strobe <= 1'b1;
            end else begin
              state          <= DONE;
              bus.frame_done <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (bus.abort) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            bus.in_ready <= 1'b1;
            bus.data     <= 1'b0;
            bus.sel      <= '0;
            bus.strobe   <= 1'b0;
            bus.busy     <= 1'b0;
          end else if (hold_cnt == 8'(HOLD_CYCLES - 1)) begin
            hold_cnt <= '0;
            if (|mask_q) begin
              bus.sel  <= next_sel;
              bus.data <= frame_q[next_sel];
              mask_q   <= mask_q & (mask_q - NUM_CH'(1));
            end else begin
              state          <= DONE;
              bus.strobe     <= 1'b0;
              bus.data       <= 1'b0;
              bus.frame_done <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        DONE: begin
          state          <= IDLE;
          bus.frame_done <= 1'b0;
          bus.busy       <= 1'b0;
          bus.in_ready   <= 1'b1;
          bus.sel        <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
